// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The frame-field enum records the on-wire order of a load frame.
package program_loader_pkg;

   localparam int LEN_WIDTH = 16;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      FIELD_LEN_HI,
      FIELD_LEN_LO,
      FIELD_PAYLOAD,
      FIELD_CHECKSUM
   } frame_field_t;

   // A header may name exactly 2^addr_width words, but never more.
   function automatic logic exceeds_capacity(input logic [LEN_WIDTH-1:0] n,
                                             input int addr_width);
      logic [LEN_WIDTH:0] cap;
      cap = (LEN_WIDTH+1)'(1) << addr_width;
      return {1'b0, n} > cap;
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
// The master side is the loader itself.
interface program_loader_if #(parameter int ADDR_WIDTH = 10);

   logic                                  start;
   logic [7:0]                            byte_in;
   logic                                  byte_valid;
   logic                                  byte_ready;
   logic [ADDR_WIDTH-1:0]                 mem_addr;
   logic [31:0]                           mem_write_data;
   logic                                  mem_write;
   logic                                  cpu_reset;
   logic                                  done;
   logic                                  error;
   logic [program_loader_pkg::LEN_WIDTH-1:0] word_count;

   modport master (
      input  start, byte_in, byte_valid,
      output byte_ready, mem_addr, mem_write_data, mem_write,
             cpu_reset, done, error, word_count
   );

   modport slave (
      output start, byte_in, byte_valid,
      input  byte_ready, mem_addr, mem_write_data, mem_write,
             cpu_reset, done, error, word_count
   );

endinterface

// File: rtl/program_loader_byte_to_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid pulses for one
// cycle on the cycle after the fourth byte of each word was accepted.
module byte_to_word_packer
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        fourth_byte,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  byte_cnt;
   logic [23:0] shift_q;

   assign fourth_byte = byte_en && (byte_cnt == 2'd3);

   // The word register holds the last assembled word between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt   <= 2'd0;
         shift_q    <= 24'd0;
         word       <= NOP_WORD;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_cnt <= 2'd0;
         end else if (byte_en) begin
            if (fourth_byte) begin
               word       <= {shift_q, byte_in};
               word_valid <= 1'b1;
            end
            shift_q  <= {shift_q[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream into instruction memory and holds the CPU in
// reset until a load finishes with a matching checksum.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
)
(
   input logic               clk,
   input logic               rst,
   program_loader_if.master  bus
);

   state_t                 state, state_next;
   logic [7:0]             len_hi;
   logic [LEN_WIDTH-1:0]   word_count;
   logic [LEN_WIDTH-1:0]   words_left;
   logic [LEN_WIDTH-1:0]   frame_len;
   logic [ADDR_WIDTH-1:0]  word_idx;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [7:0]             checksum;
   logic                   xfer;
   logic                   data_xfer;
   logic                   start_load;
   logic                   fourth_byte;
   logic                   word_valid;
   logic [31:0]            packed_word;

   assign bus.byte_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                           (state == ST_DATA)   || (state == ST_CHECK);
   assign xfer           = bus.byte_valid && bus.byte_ready;
   assign data_xfer      = xfer && (state == ST_DATA);
   assign frame_len      = {len_hi, bus.byte_in};

   assign bus.mem_write      = word_valid;
   assign bus.mem_write_data = packed_word;
   assign bus.mem_addr       = addr_q;
   assign bus.word_count     = word_count;

   byte_to_word_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clear       (start_load),
      .byte_en     (data_xfer),
      .byte_in     (bus.byte_in),
      .fourth_byte (fourth_byte),
      .word        (packed_word),
      .word_valid  (word_valid)
   );

   // Next state and status levels; Start only matters once a load is over.
   always_comb begin
      state_next    = state;
      start_load    = 1'b0;
      bus.cpu_reset = 1'b1;
      bus.done      = 1'b0;
      bus.error     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               start_load = 1'b1;
               state_next = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (xfer) state_next = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) begin
               if (exceeds_capacity(frame_len, ADDR_WIDTH))
                  state_next = ST_ERR;
               else if (frame_len == '0)
                  state_next = ST_CHECK;
               else
                  state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (xfer && fourth_byte && (words_left == LEN_WIDTH'(1)))
               state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (xfer) state_next = (bus.byte_in == checksum) ? ST_DONE : ST_ERR;
         end
         ST_DONE: begin
            bus.done      = 1'b1;
            bus.cpu_reset = 1'b0;
            if (bus.start) begin
               start_load = 1'b1;
               state_next = ST_LEN_HI;
            end
         end
         ST_ERR: begin
            bus.error = 1'b1;
            if (bus.start) begin
               start_load = 1'b1;
               state_next = ST_LEN_HI;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The write address is captured with the 4th byte so it lines up with the
   // packer's strobe one cycle later and keeps its value after the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         len_hi     <= 8'd0;
         word_count <= '0;
         words_left <= '0;
         word_idx   <= '0;
         addr_q     <= '0;
         checksum   <= 8'd0;
      end else begin
         state <= state_next;
         if (start_load) begin
            checksum <= 8'd0;
            word_idx <= '0;
         end
         case (state)
            ST_LEN_HI: begin
               if (xfer) len_hi <= bus.byte_in;
            end
            ST_LEN_LO: begin
               if (xfer) begin
                  word_count <= frame_len;
                  words_left <= frame_len;
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  checksum <= checksum ^ bus.byte_in;
                  if (fourth_byte) begin
                     addr_q     <= word_idx;
                     word_idx   <= word_idx + 1'b1;
                     words_left <= words_left - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 10-bit-address instance and a 2-bit
// instance share one stimulus stream so the capacity boundary can be reached.
`timescale 1ns/1ps
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] byteIn;
   logic       byteValid;
   logic       useB;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         logA[$];
   wr_t         logB[$];
   logic [7:0]  frame[$];
   logic [31:0] expWords[$];

   always #5 clk = ~clk;

   program_loader_if #(.ADDR_WIDTH(10)) busA ();
   program_loader_if #(.ADDR_WIDTH(2))  busB ();

   assign busA.start      = start;
   assign busA.byte_in    = byteIn;
   assign busA.byte_valid = byteValid;
   assign busB.start      = start;
   assign busB.byte_in    = byteIn;
   assign busB.byte_valid = byteValid;

   program_loader #(.ADDR_WIDTH(10)) dutA (.clk(clk), .rst(rst), .bus(busA));
   program_loader #(.ADDR_WIDTH(2))  dutB (.clk(clk), .rst(rst), .bus(busB));

   // Record every memory write strobe of both instances.
   always @(negedge clk) begin
      if (busA.mem_write) logA.push_back({16'(busA.mem_addr), busA.mem_write_data});
      if (busB.mem_write) logB.push_back({16'(busB.mem_addr), busB.mem_write_data});
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   function automatic logic curReady();
      return useB ? busB.byte_ready : busA.byte_ready;
   endfunction

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int waited = 0;
      byteIn    = b;
      byteValid = 1'b1;
      while (!curReady() && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) checkOutput("ready_timeout", 32'(curReady()), 32'd1);
      @(negedge clk);
      byteValid = 1'b0;
   endtask

   // Sends the current frame; optionally checks each strobe on instance A.
   task automatic applyStimulus(input logic withStart, input int maxGap,
                                input logic checkStrobes);
      int n = {frame[0], frame[1]};
      if (withStart) pulseStart();
      for (int i = 0; i < frame.size(); i++) begin
         if (maxGap > 0) repeat ($urandom_range(0, maxGap)) @(negedge clk);
         sendByte(frame[i]);
         if (checkStrobes && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
            checkOutput("strobe", 32'(busA.mem_write), 32'd1);
            checkOutput("strobe_addr", 32'(busA.mem_addr), 32'((i - 2) / 4));
            checkOutput("strobe_data", busA.mem_write_data, expWords[(i - 2) / 4]);
         end
      end
      @(negedge clk);
   endtask

   task automatic checkWrites(input string tag, input logic onB);
      int n = onB ? logB.size() : logA.size();
      checkOutput({tag, "_count"}, 32'(n), 32'(expWords.size()));
      for (int i = 0; i < n && i < expWords.size(); i++) begin
         wr_t w = onB ? logB[i] : logA[i];
         checkOutput({tag, "_addr"}, 32'(w.addr), 32'(i));
         checkOutput({tag, "_data"}, w.data, expWords[i]);
      end
   endtask

   task automatic checkStatusA(input string tag, input logic d, input logic e,
                               input logic cr);
      checkOutput({tag, "_done"}, 32'(busA.done), 32'(d));
      checkOutput({tag, "_error"}, 32'(busA.error), 32'(e));
      checkOutput({tag, "_cpu_reset"}, 32'(busA.cpu_reset), 32'(cr));
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic loadNominal();
      expWords = '{32'h2008_0005, 32'h0109_5020};
      frame    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; byteIn = 8'h00; byteValid = 1'b0; useB = 1'b0;
      repeat (3) @(negedge clk);

      checkStatusA("rst", 1'b0, 1'b0, 1'b1);
      checkOutput("rst_ready", 32'(busA.byte_ready), 32'd0);
      checkOutput("rst_mem_write", 32'(busA.mem_write), 32'd0);
      checkOutput("rst_mem_addr", 32'(busA.mem_addr), 32'd0);
      checkOutput("rst_wdata", busA.mem_write_data, 32'd0);
      checkOutput("rst_word_count", 32'(busA.word_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", 32'(busA.byte_ready), 32'd0);

      // Nominal two-word load.
      loadNominal();
      logA.delete();
      applyStimulus(1'b1, 0, 1'b1);
      checkWrites("nominal", 1'b0);
      checkStatusA("nominal", 1'b1, 1'b0, 1'b0);
      checkOutput("nominal_word_count", 32'(busA.word_count), 32'd2);

      // Same frame with a corrupted checksum byte.
      frame[10] = 8'h54;
      logA.delete();
      applyStimulus(1'b1, 0, 1'b1);
      checkWrites("badsum", 1'b0);
      checkStatusA("badsum", 1'b0, 1'b1, 1'b1);

      // Empty frames, good and bad checksum.
      expWords.delete();
      frame = '{8'h00, 8'h00, 8'h00};
      logA.delete();
      applyStimulus(1'b1, 0, 1'b0);
      checkWrites("empty", 1'b0);
      checkStatusA("empty", 1'b1, 1'b0, 1'b0);
      checkOutput("empty_word_count", 32'(busA.word_count), 32'd0);
      frame[2] = 8'h5A;
      applyStimulus(1'b1, 0, 1'b0);
      checkStatusA("empty_bad", 1'b0, 1'b1, 1'b1);

      // Oversize header on the 4-word instance.
      pulseReset();
      useB = 1'b1;
      frame = '{8'h00, 8'h05};
      logB.delete();
      applyStimulus(1'b1, 0, 1'b0);
      checkOutput("oversize_error", 32'(busB.error), 32'd1);
      checkOutput("oversize_ready", 32'(busB.byte_ready), 32'd0);
      checkOutput("oversize_writes", 32'(logB.size()), 32'd0);
      checkOutput("oversize_word_count", 32'(busB.word_count), 32'd5);
      pulseReset();

      // Exactly full memory on the 4-word instance, including a NOP word.
      expWords = '{32'h0000_0000, 32'h1122_3344, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      frame = '{8'h00, 8'h04,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
      logB.delete();
      applyStimulus(1'b1, 0, 1'b0);
      checkWrites("full", 1'b1);
      checkOutput("full_done", 32'(busB.done), 32'd1);
      checkOutput("full_last_addr", 32'(busB.mem_addr), 32'd3);
      useB = 1'b0;

      // Nominal load with random stream gaps.
      loadNominal();
      logA.delete();
      applyStimulus(1'b1, 3, 1'b1);
      checkWrites("stall", 1'b0);
      checkStatusA("stall", 1'b1, 1'b0, 1'b0);

      // Reset in the middle of the payload, then a clean reload.
      pulseStart();
      for (int i = 0; i < 8; i++) sendByte(frame[i]);
      rst = 1'b1;
      @(negedge clk);
      checkStatusA("midrst", 1'b0, 1'b0, 1'b1);
      checkOutput("midrst_mem_write", 32'(busA.mem_write), 32'd0);
      checkOutput("midrst_ready", 32'(busA.byte_ready), 32'd0);
      checkOutput("midrst_word_count", 32'(busA.word_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      logA.delete();
      applyStimulus(1'b1, 0, 1'b1);
      checkWrites("reload", 1'b0);
      checkStatusA("reload", 1'b1, 1'b0, 1'b0);

      // Start during DATA is ignored.
      logA.delete();
      pulseStart();
      for (int i = 0; i < 4; i++) sendByte(frame[i]);
      pulseStart();
      for (int i = 4; i < frame.size(); i++) sendByte(frame[i]);
      @(negedge clk);
      checkWrites("start_in_data", 1'b0);
      checkStatusA("start_in_data", 1'b1, 1'b0, 1'b0);

      // Start in DONE re-arms the CPU reset and overwrites from address 0.
      pulseStart();
      checkStatusA("redo", 1'b0, 1'b0, 1'b1);
      checkOutput("redo_ready", 32'(busA.byte_ready), 32'd1);
      expWords = '{32'hCAFE_BABE};
      frame = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
      logA.delete();
      applyStimulus(1'b0, 0, 1'b1);
      checkWrites("second", 1'b0);
      checkStatusA("second", 1'b1, 1'b0, 1'b0);
      checkOutput("second_word_count", 32'(busA.word_count), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface. Receives a framed byte stream, assembles big-endian 32-bit MIPS instruction words and writes them to consecutive word addresses of instruction memory.
- Holds the processor in reset while loading and releases it only after a verified load.
- Sits beside the InstructionFetchUnit. Its memory write port muxes into the instruction memory while CpuReset is high.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- LEN_WIDTH, 16, width of the word-count header field; must be 16.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE and ERR.
- ByteIn  in  8  stream data byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- MemAddr  out  ADDR_WIDTH  instruction-memory word address.
- MemWriteData  out  32  assembled instruction word.
- MemWrite  out  1  one-cycle write strobe.
- CpuReset  out  1  processor reset hold.
- Done  out  1  load completed and checksum matched (level).
- Error  out  1  load aborted (level).
- WordCount  out  LEN_WIDTH  header value N of the last accepted frame.

Behaviour:
- Frame format, in this order:
  - LEN_HI byte, then LEN_LO byte; together they give N, big-endian.
  - N*4 payload bytes; each word is MSB byte first.
  - 1 checksum byte, equal to the XOR of all payload bytes. The header is excluded from the checksum.
- Transfer rule: a byte transfers when ByteValid and ByteReady are both high on a rising Clk edge.
  - ByteReady is high only in LEN_HI, LEN_LO, DATA and CHECK.
  - ByteReady is combinational from state only; it never depends on ByteValid.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
- Reset (synchronous, and it overrides everything, including mid-load):
  - State goes to IDLE.
  - CpuReset=1; ByteReady=0; MemWrite=0; Done=0; Error=0.
  - MemAddr=0; MemWriteData=0; WordCount=0.
  - Internal byte counter, word counter and checksum accumulator all cleared.
  - A partially written program is abandoned; memory contents are not cleared.
- State transitions:
  - IDLE: Start goes to LEN_HI. CpuReset stays 1.
  - LEN_HI: on transfer, latch N[15:8].
  - LEN_LO: on transfer, latch N[7:0] and update WordCount.
    - If N > 2^ADDR_WIDTH, go to ERR.
    - Else if N == 0, go to CHECK.
    - Else go to DATA.
  - DATA: shift each transferred byte into a word register and XOR it into the checksum.
    - On the 4th byte of a word, in the next cycle: MemWrite=1 for exactly one cycle, MemAddr = word index (starting at 0), MemWriteData = assembled word.
    - Latency from 4th-byte transfer to the MemWrite strobe is 1 cycle.
    - After the Nth word's 4th byte, go to CHECK. The final MemWrite strobe occurs in CHECK's first cycle.
    - ByteReady stays high during the strobe cycle (back-to-back streaming at 1 byte per cycle is supported).
  - CHECK: on transfer, compare the byte with the accumulator.
    - Equal: go to DONE.
    - Not equal: go to ERR.
  - DONE: Done=1, CpuReset=0. Start clears Done, sets CpuReset=1 and goes to LEN_HI (reload).
  - ERR: Error=1, CpuReset=1. Start clears Error and goes to LEN_HI.
- Boundaries:
  - Start in any loading state is ignored.
  - A stalled stream (ByteValid=0) holds all state indefinitely; there is no timeout.
  - N == 2^ADDR_WIDTH is legal. The last MemAddr is all-ones; the address never wraps.
  - Word 0x00000000 (NOP) is written like any other word.
  - Done and Error are never high at the same time.

Decomposition:
- Shared package holds:
  - the state enum;
  - LEN_WIDTH;
  - constant NOP_WORD = 32'h0;
  - the frame-field order constants.
- Natural sub-module: byte_to_word_packer.
  - Inputs: a 2-bit byte counter, shift register and 4th-byte flag.
  - Output: a 32-bit word with a valid pulse.
  - Reused later for a data-memory loader.

Test Plan:
- Nominal load: Start; bytes 00 02, 20 08 00 05, 01 09 50 20, checksum.
  - MemWrite at addr 0 with 0x20080005, then addr 1 with 0x01095020.
  - Then Done=1, CpuReset=0, WordCount=2.
- Bad checksum: same frame with the last byte XORed by 0x01.
  - Both words are still written; Error=1, CpuReset stays 1, Done=0.
- Empty frame: 00 00 then checksum 00.
  - No MemWrite; Done=1.
  - The same frame with checksum 5A gives Error=1.
- Oversize header with ADDR_WIDTH=2: header 00 05.
  - ERR immediately after LEN_LO; no MemWrite; ByteReady=0.
  - Header 00 04 with 16 payload bytes: last write at MemAddr=3, then Done.
- Stalls and reset: random ByteValid gaps give the same writes as the nominal load.
  - Reset asserted after 6 payload bytes: the next cycle is IDLE, with CpuReset=1, Done=0, Error=0, MemWrite=0.
  - Restarting from there loads correctly from address 0.
- Start handling: Start asserted during DATA is ignored.
  - Start in DONE sets CpuReset=1 and begins a reload; the second frame overwrites from address 0.
